// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle logic/add/sub, shift-add multiply
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [2:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0] mcand, mcand_nxt;
   logic [WIDTH-1:0] mplier, mplier_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic [WIDTH-1:0] partial_sum;
   logic             accept;

   // State and datapath registers; reset aborts any multiply in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         data_o <= '0;
      end else begin
         state  <= state_nxt;
         acc    <= acc_nxt;
         mcand  <= mcand_nxt;
         mplier <= mplier_nxt;
         cnt    <= cnt_nxt;
         data_o <= data_nxt;
      end
   end

   // Next-state and datapath updates: issue decode, shift-add step, result load
   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      mcand_nxt   = mcand;
      mplier_nxt  = mplier;
      cnt_nxt     = cnt;
      data_nxt    = data_o;
      accept      = start_i && (state == IDLE || state == DONE);
      partial_sum = acc + (mplier[0] ? mcand : '0);

      case (state)
         MUL: begin
            acc_nxt    = partial_sum;
            mcand_nxt  = mcand << 1;
            mplier_nxt = mplier >> 1;
            cnt_nxt    = cnt + CW'(1);
            // Last iteration: counter about to wrap to zero
            if (cnt == CW'(WIDTH - 1)) begin
               data_nxt  = partial_sum;
               state_nxt = DONE;
            end
         end
         default: begin
            if (state == DONE)
               state_nxt = IDLE;
            if (accept) begin
               state_nxt = DONE;
               case (ALUCtrl_i)
                  OP_AND: data_nxt = data1_i & data2_i;
                  OP_OR:  data_nxt = data1_i | data2_i;
                  OP_ADD: data_nxt = data1_i + data2_i;
                  OP_SUB: data_nxt = data1_i - data2_i;
                  OP_MUL: begin
                     state_nxt  = MUL;
                     acc_nxt    = '0;
                     mcand_nxt  = data1_i;
                     mplier_nxt = data2_i;
                     cnt_nxt    = '0;
                  end
                  default: data_nxt = '0;
               endcase
            end
         end
      endcase
   end

   // Status outputs decoded from state and the result register
   always_comb begin
      busy_o  = (state == MUL);
      valid_o = (state == DONE);
      zero_o  = (data_o == '0);
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq
module tb_alu_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  ctrl;
   logic [31:0] d1, d2;
   logic        busy, valid, zero;
   logic [31:0] data;

   int n_cmp = 0;
   int n_err = 0;

   alu_seq #(.WIDTH(32)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .ALUCtrl_i (ctrl),
      .data1_i   (d1),
      .data2_i   (d2),
      .busy_o    (busy),
      .valid_o   (valid),
      .data_o    (data),
      .zero_o    (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] prod;
      case (op)
         3'b000: return a & b;
         3'b001: return a | b;
         3'b010: return a + b;
         3'b011: begin prod = {32'd0, a} * {32'd0, b}; return prod[31:0]; end
         3'b110: return a - b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] op);
      return (op == 3'b011) ? 33 : 1;
   endfunction

   // Issue one operation, scramble inputs after capture, observe result and timing
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int pulse_at, output logic [31:0] res, output logic z,
                         output int lat, output int busy_cnt);
      int cyc;
      @(negedge clk);
      ctrl = op; d1 = a; d2 = b; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; ctrl = 3'($urandom); d1 = $urandom; d2 = $urandom;
      lat = 0; busy_cnt = 0; cyc = 1;
      while (cyc < 100) begin
         if (valid) begin
            lat = cyc;
            break;
         end
         if (busy) busy_cnt++;
         start = (cyc == pulse_at);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      res = data;
      z = zero;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; ctrl = 3'b000; d1 = 32'd0; d2 = 32'd0;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid); end
      n_cmp++; if (data !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h expected 0", data); end
      n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b expected 1", zero); end
      rst = 1'b0;
   endtask

   task automatic test_add();
      logic [31:0] r; logic z; int lat, bc;
      run_op(3'b010, 32'd7, 32'd5, 0, r, z, lat, bc);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL add_latency: got %0d expected 1", lat); end
      n_cmp++; if (r !== 32'd12) begin n_err++; $display("FAIL add_data: got %h expected 0000000c", r); end
      n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL add_zero: got %b expected 0", z); end
      @(negedge clk);
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL add_pulse_width: valid got %b expected 0", valid); end
      n_cmp++; if (data !== 32'd12) begin n_err++; $display("FAIL add_hold: got %h expected 0000000c", data); end
   endtask

   task automatic test_sub();
      logic [31:0] r; logic z; int lat, bc;
      run_op(3'b110, 32'd5, 32'd5, 0, r, z, lat, bc);
      n_cmp++; if (r !== 32'd0) begin n_err++; $display("FAIL sub_equal_data: got %h expected 0", r); end
      n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL sub_equal_zero: got %b expected 1", z); end
      run_op(3'b110, 32'd0, 32'd1, 0, r, z, lat, bc);
      n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sub_borrow_data: got %h expected ffffffff", r); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL sub_latency: got %0d expected 1", lat); end
   endtask

   task automatic test_mul();
      logic [31:0] r; logic z; int lat, bc;
      run_op(3'b011, 32'h0001_0003, 32'h0001_0002, 10, r, z, lat, bc);
      n_cmp++; if (bc !== 32) begin n_err++; $display("FAIL mul_busy_cycles: got %0d expected 32", bc); end
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_latency: got %0d expected 33", lat); end
      n_cmp++; if (r !== 32'h0005_0006) begin n_err++; $display("FAIL mul_data: got %h expected 00050006", r); end
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r, z, lat, bc);
      n_cmp++; if (r !== 32'h0000_0001) begin n_err++; $display("FAIL mul_ones_data: got %h expected 00000001", r); end
      run_op(3'b011, 32'd0, 32'h1234, 0, r, z, lat, bc);
      n_cmp++; if (r !== 32'd0) begin n_err++; $display("FAIL mul_zero_data: got %h expected 0", r); end
      n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL mul_zero_flag: got %b expected 1", z); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      ctrl = 3'b000; d1 = 32'hF0F0; d2 = 32'hFF00; start = 1'b1;
      @(negedge clk);
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid_first: got %b expected 1", valid); end
      n_cmp++; if (data !== 32'hF000) begin n_err++; $display("FAIL b2b_data_first: got %h expected 0000f000", data); end
      ctrl = 3'b001; d1 = 32'h1; d2 = 32'h2;
      @(negedge clk);
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid_second: got %b expected 1", valid); end
      n_cmp++; if (data !== 32'h3) begin n_err++; $display("FAIL b2b_data_second: got %h expected 00000003", data); end
      start = 1'b0;
      @(negedge clk);
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_end: got %b expected 0", valid); end
      n_cmp++; if (data !== 32'h3) begin n_err++; $display("FAIL b2b_hold: got %h expected 00000003", data); end
   endtask

   task automatic test_reset_mid_mul();
      logic [31:0] r; logic z; int lat, bc, pulses;
      run_op(3'b010, 32'd100, 32'd1, 0, r, z, lat, bc);
      @(negedge clk);
      ctrl = 3'b011; d1 = 32'd3; d2 = 32'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_mul_busy_before: got %b expected 1", busy); end
      rst = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mul_busy: got %b expected 0", busy); end
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_mul_valid: got %b expected 0", valid); end
      n_cmp++; if (data !== 32'd0) begin n_err++; $display("FAIL rst_mul_data: got %h expected 0", data); end
      n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL rst_mul_zero: got %b expected 1", zero); end
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rst_mul_no_pulse: got %0d pulses expected 0", pulses); end
      run_op(3'b111, $urandom | 32'h1, $urandom | 32'h1, 0, r, z, lat, bc);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL undef_latency: got %0d expected 1", lat); end
      n_cmp++; if (r !== 32'd0) begin n_err++; $display("FAIL undef_data: got %h expected 0", r); end
   endtask

   task automatic test_random();
      logic [2:0] ops [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100, 3'b101, 3'b111};
      for (int i = 0; i < 40; i++) begin
         logic [2:0] op; logic [31:0] a, b, exp, r; logic z; int lat, bc;
         op = ops[$urandom_range(0, 7)];
         a = (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         b = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
         exp = ref_result(op, a, b);
         run_op(op, a, b, 0, r, z, lat, bc);
         n_cmp++; if (r !== exp) begin n_err++; $display("FAIL rand_data[%0d] op=%b a=%h b=%h: got %h expected %h", i, op, a, b, r, exp); end
         n_cmp++; if (lat !== ref_latency(op)) begin n_err++; $display("FAIL rand_latency[%0d] op=%b: got %0d expected %0d", i, op, lat, ref_latency(op)); end
         n_cmp++; if (z !== (exp == 32'd0)) begin n_err++; $display("FAIL rand_zero[%0d]: got %b expected %b", i, z, exp == 32'd0); end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_back_to_back();
      test_reset_mid_mul();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand and result width in bits.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start_i  input  1  request to begin an operation; sampled only when busy_o=0.
REQ-005 SHALL have port: ALUCtrl_i  input  3  operation code: AND=000, OR=001, ADD=010, MUL=011, SUB=110.
REQ-006 SHALL have port: data1_i  input  WIDTH  first operand (minuend / multiplicand).
REQ-007 SHALL have port: data2_i  input  WIDTH  second operand (subtrahend / multiplier).
REQ-008 SHALL have port: busy_o  output  1  high while a multi-cycle MUL is in progress.
REQ-009 SHALL have port: valid_o  output  1  one-cycle pulse marking a new result on data_o.
REQ-010 SHALL have port: data_o  output  WIDTH  registered result.
REQ-011 SHALL have port: zero_o  output  1  high when data_o equals 0.

Function
REQ-012 SHALL implement a state machine with states IDLE, MUL, DONE.
REQ-013 SHALL accept a start when start_i=1 and the state is IDLE or DONE; ALUCtrl_i, data1_i and data2_i are captured on that edge.
REQ-014 SHALL ignore start_i and input changes while in MUL.
REQ-015 SHALL, for an accepted AND/OR/ADD/SUB, load data_o with the result and enter DONE on the same edge, so valid_o=1 in the cycle following the start (latency 1).
REQ-016 SHALL compute ADD and SUB modulo 2^WIDTH: carry and borrow are discarded and there is no overflow flag.
REQ-017 SHALL, for an accepted undefined code (100, 101, 111), load data_o with 0 and enter DONE (latency 1).
REQ-018 SHALL, for an accepted MUL, enter MUL: clear the accumulator, load the multiplicand and multiplier, and clear a 5-bit (log2 WIDTH) iteration counter.
REQ-019 SHALL, on each MUL cycle, add the multiplicand to the accumulator when the multiplier LSB is 1, shift the multiplicand left by 1 and the multiplier right by 1, and increment the counter.
REQ-020 SHALL leave MUL after WIDTH iterations (counter wrap 31->0), load data_o with the low WIDTH bits of the product, and enter DONE; latency is WIDTH+1 cycles from start (33 for WIDTH=32).
REQ-021 SHALL discard the upper WIDTH bits of the product and treat operands as unsigned; the low word is therefore also correct for two's-complement operands.
REQ-022 SHALL drive busy_o=1 exactly when the state is MUL.
REQ-023 SHALL drive valid_o=1 exactly when the state is DONE, which lasts one cycle.
REQ-024 SHALL, in DONE, go to IDLE when start_i=0, or accept a new operation when start_i=1 (back-to-back issue, no bubble).
REQ-025 SHALL hold data_o unchanged between results.
REQ-026 SHALL derive zero_o combinationally from data_o.

Reset
REQ-027 SHALL, while rst_i=1, immediately force the state to IDLE, busy_o=0, valid_o=0 and data_o=0 (so zero_o=1), and clear the accumulator and counter.
REQ-028 SHALL abort an in-progress MUL on reset with no valid_o pulse; the first start after reset deasserts is accepted normally.

Verification
REQ-029 SHALL cover: ADD 7+5 -> valid_o pulse one cycle after start, data_o=12, zero_o=0.
REQ-030 SHALL cover: SUB 5-5 -> data_o=0 and zero_o=1; SUB 0-1 -> data_o=0xFFFFFFFF.
REQ-031 SHALL cover: MUL 0x0001_0003 * 0x0001_0002 -> busy_o=1 for 32 cycles, valid_o at cycle 33, data_o=0x0005_0006; start_i pulsed mid-MUL is ignored.
REQ-032 SHALL cover: MUL 0xFFFFFFFF * 0xFFFFFFFF -> data_o=0x00000001; MUL 0 * 0x1234 -> data_o=0, zero_o=1.
REQ-033 SHALL cover: back-to-back AND 0xF0F0&0xFF00 then OR 0x1|0x2 with start_i held high -> valid_o high on two consecutive cycles, data_o=0xF000 then 0x3.
REQ-034 SHALL cover: rst_i asserted at MUL cycle 10 -> busy_o, valid_o and data_o go to 0 immediately with no valid_o pulse; ALUCtrl_i=111 after reset -> data_o=0 with a valid_o pulse.
